wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter.sv | 111 +++++++++++
 tb/tb_wb_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: the pipeline shares one write port with a small FIFO of
// long-latency (mul/div) results. A starvation counter forces a buffer grant by stalling the pipeline.
module wb_arbiter #(
  parameter int STARVE_LIM = 3,
  parameter int DEPTH      = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [4:0]               pipe_rd,
  input  logic [31:0]              pipe_data,
  input  logic                     lu_valid,
  output logic                     lu_ready,
  input  logic [4:0]               lu_rd,
  input  logic [31:0]              lu_data,
  output logic                     stall_pipe,
  output logic                     rf_we,
  output logic [4:0]               rf_waddr,
  output logic [31:0]              rf_wdata,
  output logic [$clog2(DEPTH):0]   buf_cnt
);

  // DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_LIM + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [SW-1:0] LIM  = SW'(STARVE_LIM);

  logic [4:0]       buf_rd   [DEPTH];
  logic [31:0]      buf_data [DEPTH];
  logic [DEPTH-1:0] buf_vld;
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [SW-1:0]    starve;
  logic [SW-1:0]    starve_nxt;

  logic buf_nonempty;
  logic push;
  logic gnt_pipe;
  logic gnt_buf;

  // Grant uses the registered occupancy, so a result pushed this cycle is never bypassed.
  always_comb begin
    buf_nonempty = (buf_cnt != '0);
    lu_ready     = (buf_cnt < FULL);
    push         = lu_valid && lu_ready;
    gnt_pipe     = !stall_pipe && pipe_we;
    gnt_buf      = buf_nonempty && (stall_pipe || !pipe_we);
  end

  always_comb begin
    starve_nxt = starve;
    if (!buf_nonempty || gnt_buf)
      starve_nxt = '0;
    else if (gnt_pipe && (starve != LIM))
      starve_nxt = starve + SW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      buf_vld    <= '0;
      buf_cnt    <= '0;
      starve     <= '0;
      stall_pipe <= 1'b0;
      rf_we      <= 1'b0;
      rf_waddr   <= 5'd0;
      rf_wdata   <= 32'h0000_0000;
    end else begin
      rf_we <= 1'b0;
      if (gnt_pipe) begin
        rf_we    <= (pipe_rd != 5'd0);
        rf_waddr <= pipe_rd;
        rf_wdata <= pipe_data;
      end else if (gnt_buf) begin
        rf_we    <= buf_vld[rd_ptr] && (buf_rd[rd_ptr] != 5'd0);
        rf_waddr <= buf_rd[rd_ptr];
        rf_wdata <= buf_data[rd_ptr];
        rd_ptr   <= rd_ptr + PW'(1);
      end

      // A newer pipeline write to the same rd makes older buffered results dead.
      // The slot being pushed is empty, so the push below safely overrides its valid bit.
      if (gnt_pipe && (pipe_rd != 5'd0)) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (buf_rd[i] == pipe_rd)
            buf_vld[i] <= 1'b0;
        end
      end

      if (push) begin
        buf_rd[wr_ptr]   <= lu_rd;
        buf_data[wr_ptr] <= lu_data;
        buf_vld[wr_ptr]  <= 1'b1;
        wr_ptr           <= wr_ptr + PW'(1);
      end

      case ({push, gnt_buf})
        2'b10:   buf_cnt <= buf_cnt + CW'(1);
        2'b01:   buf_cnt <= buf_cnt - CW'(1);
        default: buf_cnt <= buf_cnt;
      endcase

      starve     <= starve_nxt;
      stall_pipe <= (starve_nxt == LIM);
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios plus randomized traffic
// compared against a queue-based reference model.
module tb_wb_arbiter;
  localparam int DEPTH      = 2;
  localparam int STARVE_LIM = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pipe_we = 1'b0;
  logic [4:0]  pipe_rd = '0;
  logic [31:0] pipe_data = '0;
  logic        lu_valid = 1'b0;
  logic        lu_ready;
  logic [4:0]  lu_rd = '0;
  logic [31:0] lu_data = '0;
  logic        stall_pipe;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [$clog2(DEPTH):0] buf_cnt;

  wb_arbiter #(.STARVE_LIM(STARVE_LIM), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .pipe_we(pipe_we), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
    .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
    .stall_pipe(stall_pipe), .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .buf_cnt(buf_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    bit          vld;
  } ent_t;

  ent_t        m_q[$];
  int          m_starve = 0;
  bit          m_stall = 0;
  bit          e_we = 0;
  logic [4:0]  e_waddr = '0;
  logic [31:0] e_wdata = '0;

  // Advance the reference model by one cycle from the applied inputs, then clock the DUT.
  task automatic tick();
    int n;
    bit psh, gp, gb;
    ent_t e;
    n = m_q.size();
    if (rst) begin
      m_q.delete();
      m_starve = 0; m_stall = 0;
      e_we = 0; e_waddr = '0; e_wdata = '0;
    end else begin
      psh = lu_valid && (n < DEPTH);
      gp  = !m_stall && pipe_we;
      gb  = (n > 0) && (m_stall || !pipe_we);
      e_we = 0;
      if (gp) begin
        e_we = (pipe_rd != 0); e_waddr = pipe_rd; e_wdata = pipe_data;
        if (pipe_rd != 0)
          foreach (m_q[i]) if (m_q[i].rd == pipe_rd) m_q[i].vld = 0;
      end else if (gb) begin
        e = m_q.pop_front();
        e_we = e.vld && (e.rd != 0); e_waddr = e.rd; e_wdata = e.data;
      end
      if (psh) m_q.push_back('{lu_rd, lu_data, 1'b1});
      if (n == 0 || gb) m_starve = 0;
      else if (gp && m_starve < STARVE_LIM) m_starve++;
      m_stall = (m_starve == STARVE_LIM);
    end
    @(posedge clk); #1;
  endtask

  task automatic drive(input bit pwe, input logic [4:0] prd, input logic [31:0] pd,
                       input bit lv, input logic [4:0] lrd, input logic [31:0] ld);
    pipe_we = pwe; pipe_rd = prd; pipe_data = pd;
    lu_valid = lv; lu_rd = lrd; lu_data = ld;
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0);
    rst = 1; tick(); rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; tick(); tick(); rst = 0;
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_rf_we: got %0b expected 0", rf_we); end
    n_tests++; if (rf_waddr !== 5'd0) begin n_fail++; $display("FAIL reset_waddr: got %0d expected 0", rf_waddr); end
    n_tests++; if (rf_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata: got %08h expected 0", rf_wdata); end
    n_tests++; if (buf_cnt !== 2'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d expected 0", buf_cnt); end
    n_tests++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b expected 0", stall_pipe); end
    n_tests++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b expected 1", lu_ready); end
  endtask

  task automatic test_pipe_only();
    drive(1, 5'd5, 32'h1234_5678, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234_5678) begin
      n_fail++; $display("FAIL pipe_only: got we=%0b a=%0d d=%08h expected we=1 a=5 d=12345678", rf_we, rf_waddr, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL pipe_idle: got %0b expected 0", rf_we); end
  endtask

  task automatic test_x0();
    drive(1, 5'd0, 32'hFFFF_FFFF, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL x0_write: got %0b expected 0", rf_we); end
  endtask

  task automatic test_fill_starve();
    do_reset();
    drive(1, 5'd3, 32'h11, 1, 5'd7, 32'hA); tick();
    drive(1, 5'd3, 32'h22, 1, 5'd8, 32'hB); tick();
    n_tests++; if (buf_cnt !== 2'd2 || lu_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got cnt=%0d ready=%0b expected cnt=2 ready=0", buf_cnt, lu_ready); end
    drive(1, 5'd3, 32'h33, 1, 5'd9, 32'hE); tick();
    n_tests++; if (stall_pipe !== 1'b0 || buf_cnt !== 2'd2) begin
      n_fail++; $display("FAIL fill_early: got stall=%0b cnt=%0d expected stall=0 cnt=2", stall_pipe, buf_cnt); end
    drive(1, 5'd3, 32'h44, 0, 0, 0); tick();
    n_tests++; if (stall_pipe !== 1'b1) begin n_fail++; $display("FAIL starve_stall: got %0b expected 1", stall_pipe); end
    drive(1, 5'd4, 32'h55, 0, 0, 0); tick();
    n_tests++; if (stall_pipe !== 1'b0) begin n_fail++; $display("FAIL stall_one_cycle: got %0b expected 0", stall_pipe); end
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA) begin
      n_fail++; $display("FAIL forced_grant: got we=%0b a=%0d d=%08h expected we=1 a=7 d=a", rf_we, rf_waddr, rf_wdata); end
    n_tests++; if (buf_cnt !== 2'd1) begin n_fail++; $display("FAIL forced_pop_cnt: got %0d expected 1", buf_cnt); end
    drive(1, 5'd4, 32'h66, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h66) begin
      n_fail++; $display("FAIL pipe_resume: got we=%0b a=%0d d=%08h expected we=1 a=4 d=66", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_idle_drain();
    do_reset();
    drive(1, 5'd3, 32'h1, 1, 5'd7, 32'hA); tick();
    drive(1, 5'd3, 32'h2, 1, 5'd8, 32'hB); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || rf_wdata !== 32'hA) begin
      n_fail++; $display("FAIL drain_first: got we=%0b a=%0d d=%08h expected we=1 a=7 d=a", rf_we, rf_waddr, rf_wdata); end
    tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || rf_wdata !== 32'hB) begin
      n_fail++; $display("FAIL drain_second: got we=%0b a=%0d d=%08h expected we=1 a=8 d=b", rf_we, rf_waddr, rf_wdata); end
    n_tests++; if (buf_cnt !== 2'd0 || lu_ready !== 1'b1) begin
      n_fail++; $display("FAIL drain_empty: got cnt=%0d ready=%0b expected cnt=0 ready=1", buf_cnt, lu_ready); end
    tick();
    n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL drain_idle: got %0b expected 0", rf_we); end
  endtask

  task automatic test_hazard();
    do_reset();
    drive(1, 5'd3, 32'h1, 1, 5'd9, 32'hC); tick();
    drive(1, 5'd9, 32'hD, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hD) begin
      n_fail++; $display("FAIL hazard_pipe: got we=%0b a=%0d d=%08h expected we=1 a=9 d=d", rf_we, rf_waddr, rf_wdata); end
    drive(0, 0, 0, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b0 || buf_cnt !== 2'd0) begin
      n_fail++; $display("FAIL hazard_pop: got we=%0b cnt=%0d expected we=0 cnt=0", rf_we, buf_cnt); end
    // A result pushed alongside a matching pipeline write is newer and must survive.
    drive(1, 5'd9, 32'hD, 1, 5'd9, 32'hE); tick();
    drive(0, 0, 0, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hE) begin
      n_fail++; $display("FAIL hazard_same_cycle: got we=%0b a=%0d d=%08h expected we=1 a=9 d=e", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_no_bypass();
    do_reset();
    drive(0, 0, 0, 1, 5'd12, 32'h77); tick();
    n_tests++; if (rf_we !== 1'b0 || buf_cnt !== 2'd1) begin
      n_fail++; $display("FAIL no_bypass: got we=%0b cnt=%0d expected we=0 cnt=1", rf_we, buf_cnt); end
    drive(0, 0, 0, 0, 0, 0); tick();
    n_tests++; if (rf_we !== 1'b1 || rf_waddr !== 5'd12 || rf_wdata !== 32'h77) begin
      n_fail++; $display("FAIL bypass_latency: got we=%0b a=%0d d=%08h expected we=1 a=12 d=77", rf_we, rf_waddr, rf_wdata); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 5'd3, 32'h1, 1, 5'd7, 32'hA); tick();
    drive(1, 5'd3, 32'h2, 1, 5'd8, 32'hB); tick();
    drive(1, 5'd3, 32'h3, 0, 0, 0); tick();
    drive(1, 5'd3, 32'h4, 0, 0, 0);
    rst = 1; tick(); rst = 0;
    n_tests++; if (rf_we !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'h0 || buf_cnt !== 2'd0 ||
                   stall_pipe !== 1'b0 || lu_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid: got we=%0b a=%0d d=%08h cnt=%0d stall=%0b ready=%0b expected all reset",
                         rf_we, rf_waddr, rf_wdata, buf_cnt, stall_pipe, lu_ready); end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      tick();
      n_tests++; if (rf_we !== 1'b0) begin n_fail++; $display("FAIL reset_discard: cycle %0d got we=%0b expected 0", i, rf_we); end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      rst = ($urandom_range(0, 149) == 0);
      drive($urandom_range(0, 9) < 7, 5'($urandom_range(0, 3)), $urandom,
            $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)), $urandom);
      tick();
      n_tests++; if (rf_we !== e_we) begin n_fail++; $display("FAIL rand_we: cycle %0d got %0b expected %0b", c, rf_we, e_we); end
      if (e_we) begin
        n_tests++; if (rf_waddr !== e_waddr || rf_wdata !== e_wdata) begin
          n_fail++; $display("FAIL rand_wr: cycle %0d got a=%0d d=%08h expected a=%0d d=%08h", c, rf_waddr, rf_wdata, e_waddr, e_wdata); end
      end
      n_tests++; if (buf_cnt !== 2'(m_q.size())) begin n_fail++; $display("FAIL rand_cnt: cycle %0d got %0d expected %0d", c, buf_cnt, m_q.size()); end
      n_tests++; if (lu_ready !== (m_q.size() < DEPTH)) begin n_fail++; $display("FAIL rand_ready: cycle %0d got %0b", c, lu_ready); end
      n_tests++; if (stall_pipe !== m_stall) begin n_fail++; $display("FAIL rand_stall: cycle %0d got %0b expected %0b", c, stall_pipe, m_stall); end
    end
    rst = 0;
  endtask

  initial begin
    test_reset();
    test_pipe_only();
    test_x0();
    test_fill_starve();
    test_idle_drain();
    test_hazard();
    test_no_bypass();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
